// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard controller:
// receiver state encoding, register offsets and STATUS bit positions.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [11:0] KBD_REGION = 12'h003;
  localparam logic [3:0]  OFF_DATA   = 4'h0;
  localparam logic [3:0]  OFF_STATUS = 4'h4;

  localparam int STAT_READY     = 0;
  localparam int STAT_FRAME_ERR = 1;
  localparam int STAT_OVERFLOW  = 2;

endpackage

// File: rtl/kbd_ctrl_ps2_rx.sv
// PS/2 frame receiver: input synchronizers, frame FSM, parity/stop check.
// Optional no-edge timeout is built only when KBD_TIMEOUT_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for a falling edge with data=0 (start)
// ST_DATA   | shifting 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking stop bit and parity, emitting result
module ps2_rx #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);
  import kbd_pkg::*;

  logic      clk_s1, clk_s2, clk_s3;
  logic      data_s1, data_s2;
  logic      fall;
  logic      tmo_hit;
  rx_state_e state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift_reg, shift_nxt;
  logic      par_bit, par_nxt;
  logic      valid_nxt, err_nxt;

  // clk_s3 only remembers the previous synchronized level for edge detect
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  assign fall = clk_s3 & ~clk_s2;

`ifdef KBD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                tmo_cnt <= '0;
    else if (fall)             tmo_cnt <= TW'(TIMEOUT_CYC);
    else if (tmo_cnt != '0)    tmo_cnt <= tmo_cnt - 1'b1;
  end

  assign tmo_hit = (tmo_cnt == '0) && (state != ST_IDLE) && !fall;
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
      par_bit   <= par_nxt;
      rx_valid  <= valid_nxt;
      rx_err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    par_nxt     = par_bit;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    if (tmo_hit) begin
      state_nxt = ST_IDLE;
      shift_nxt = '0;
      err_nxt   = 1'b1;
    end else if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!data_s2) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
          end
        end
        ST_DATA: begin
          shift_nxt   = {data_s2, shift_reg[7:1]};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          par_nxt   = data_s2;
          state_nxt = ST_STOP;
        end
        ST_STOP: begin
          state_nxt = ST_IDLE;
          if (data_s2 && (^{shift_reg, par_bit})) valid_nxt = 1'b1;
          else                                    err_nxt   = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // shift_reg is stable from the STOP edge until the next frame's first data bit
  assign rx_byte = shift_reg;

endmodule

// File: rtl/kbd_ctrl.sv
// PS/2 keyboard controller top: scancode FIFO and CPU read decode.
// Build with KBD_TIMEOUT_EN to abandon stalled partial frames.
module kbd_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [31:0] rdaddr,
  input  logic        rdclk,
  output logic [31:0] dataout,
  output logic        kbd_ready
);
  import kbd_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  rx_byte;
  logic        rx_valid, rx_err;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        overflow, frame_err;
  logic        hit, rd_data, rd_stat, full, push, pop, ovf_set;
  logic        unused_addr;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  assign unused_addr = ^rdaddr[19:4];
  assign hit       = rdclk && (rdaddr[31:20] == KBD_REGION);
  assign rd_data   = hit && (rdaddr[3:0] == OFF_DATA);
  assign rd_stat   = hit && (rdaddr[3:0] == OFF_STATUS);
  assign kbd_ready = (count != '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = rd_data && kbd_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push      = rx_valid && (!full || pop);
  assign ovf_set   = rx_valid && full && !pop;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      dataout   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      overflow  <= 1'b1;
      else if (rd_stat) overflow  <= 1'b0;
      if (rx_err)       frame_err <= 1'b1;
      else if (rd_stat) frame_err <= 1'b0;
      if (rdclk) begin
        if (pop)          dataout <= {24'b0, mem[rd_ptr]};
        else if (rd_stat) dataout <= {29'b0, overflow, frame_err, kbd_ready};
        else              dataout <= '0;
      end
    end
  end

endmodule

// File: tb/tb_kbd_ctrl.sv
// Directed self-checking bench for kbd_ctrl: PS/2 frames are bit-banged
// and the CPU read port is checked against hand-computed values.
`timescale 1ns/1ps
module tb_kbd_ctrl;

  localparam int TMO = 200;
  localparam logic [31:0] A_DATA = 32'h0030_0000;
  localparam logic [31:0] A_STAT = 32'h0030_0004;

  logic        clock = 1'b0;
  logic        reset;
  logic        ps2_clk, ps2_data;
  logic [31:0] rdaddr;
  logic        rdclk;
  logic [31:0] dataout;
  logic        kbd_ready;

  int tests = 0;
  int fails = 0;

  kbd_ctrl #(.FIFO_DEPTH(8), .TIMEOUT_CYC(TMO)) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rdaddr    (rdaddr),
    .rdclk     (rdclk),
    .dataout   (dataout),
    .kbd_ready (kbd_ready)
  );

  always #5 clock = ~clock;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    rdaddr = a;
    rdclk  = 1'b1;
    wait_clk(1);
    rdclk  = 1'b0;
    d      = dataout;
  endtask

  // bits: start, 8 data LSB-first, odd parity, stop
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit rd_at_stop, output logic [31:0] rd_val);
    logic [10:0] bits;
    bits   = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    rd_val = '0;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_clk(2);
      ps2_clk = 1'b0;
      if (rd_at_stop && i == 10) begin
        wait_clk(3);
        rdaddr = A_DATA;
        rdclk  = 1'b1;
        wait_clk(1);
        rdclk  = 1'b0;
        rd_val = dataout;
      end else begin
        wait_clk(4);
      end
      ps2_clk = 1'b1;
      wait_clk(4);
    end
    ps2_data = 1'b1;
    wait_clk(6);
  endtask

  task automatic send(input logic [7:0] b);
    logic [31:0] dummy;
    send_frame(b, 1'b0, 1'b0, 11, 1'b0, dummy);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    tests++;
    if (dataout !== 32'h0 || kbd_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: dataout=%h ready=%b, want 0/0", dataout, kbd_ready);
    end
    rd(A_STAT, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL reset_status: got %h want 0", d); end
  endtask

  task automatic test_single;
    logic [31:0] d;
    send(8'h1C);
    tests++;
    if (kbd_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b want 1", kbd_ready); end
    rd(A_DATA, d);
    tests++;
    if (d !== 32'h0000_001C) begin fails++; $display("FAIL single_data: got %h want 0000001c", d); end
    tests++;
    if (kbd_ready !== 1'b0) begin fails++; $display("FAIL single_ready_clr: got %b want 0", kbd_ready); end
    rd(A_DATA, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL empty_read: got %h want 0", d); end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    for (int i = 1; i <= 9; i++) send(8'(i));
    rd(A_STAT, d);
    tests++;
    if (d !== 32'h5) begin fails++; $display("FAIL ovf_status: got %h want 5", d); end
    for (int i = 1; i <= 8; i++) begin
      rd(A_DATA, d);
      tests++;
      if (d !== 32'(i)) begin fails++; $display("FAIL ovf_data%0d: got %h want %h", i, d, 32'(i)); end
    end
    rd(A_STAT, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL ovf_status_clr: got %h want 0", d); end
  endtask

  task automatic test_frame_errors;
    logic [31:0] d;
    send_frame(8'h5A, 1'b1, 1'b0, 11, 1'b0, d);
    tests++;
    if (kbd_ready !== 1'b0) begin fails++; $display("FAIL par_nopush: ready=%b want 0", kbd_ready); end
    rd(A_STAT, d);
    tests++;
    if (d !== 32'h2) begin fails++; $display("FAIL par_status: got %h want 2", d); end
    rd(A_STAT, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL par_status_clr: got %h want 0", d); end
    send_frame(8'h3C, 1'b0, 1'b1, 11, 1'b0, d);
    rd(A_STAT, d);
    tests++;
    if (d !== 32'h2) begin fails++; $display("FAIL stop_status: got %h want 2", d); end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
    send_frame(8'h18, 1'b0, 1'b0, 11, 1'b1, d);
    tests++;
    if (d !== 32'h10) begin fails++; $display("FAIL pushpop_head: got %h want 10", d); end
    rd(A_STAT, d);
    tests++;
    if (d !== 32'h1) begin fails++; $display("FAIL pushpop_status: got %h want 1", d); end
    for (int i = 1; i <= 8; i++) begin
      rd(A_DATA, d);
      tests++;
      if (d !== 32'h10 + 32'(i)) begin
        fails++;
        $display("FAIL pushpop_drain%0d: got %h want %h", i, d, 32'h10 + 32'(i));
      end
    end
    tests++;
    if (kbd_ready !== 1'b0) begin fails++; $display("FAIL pushpop_empty: ready=%b want 0", kbd_ready); end
  endtask

  task automatic test_decode;
    logic [31:0] d;
    send(8'h33);
    rd(32'h0030_0008, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL dec_offset8: got %h want 0", d); end
    rd(32'h0040_0000, d);
    tests++;
    if (kbd_ready !== 1'b1) begin fails++; $display("FAIL dec_miss_nopop: ready=%b want 1", kbd_ready); end
    rd(A_DATA, d);
    tests++;
    if (d !== 32'h33) begin fails++; $display("FAIL dec_data: got %h want 33", d); end
  endtask

  task automatic test_timeout;
    logic [31:0] d;
    send_frame(8'hA5, 1'b0, 1'b0, 5, 1'b0, d);
    wait_clk(TMO + 10);
    rd(A_STAT, d);
`ifdef KBD_TIMEOUT_EN
    tests++;
    if (d !== 32'h2) begin fails++; $display("FAIL tmo_status: got %h want 2", d); end
    send(8'h29);
    rd(A_DATA, d);
    tests++;
    if (d !== 32'h29) begin fails++; $display("FAIL tmo_next_frame: got %h want 29", d); end
`else
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL notmo_status: got %h want 0", d); end
    reset = 1'b0;
    wait_clk(2);
    reset = 1'b1;
    wait_clk(2);
`endif
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d;
    send(8'h77);
    send(8'h66);
    send_frame(8'h11, 1'b1, 1'b0, 11, 1'b0, d);
    rd(A_DATA, d);
    tests++;
    if (d !== 32'h77) begin fails++; $display("FAIL rst_pre_data: got %h want 77", d); end
    send_frame(8'hC3, 1'b0, 1'b0, 6, 1'b0, d);
    ps2_clk = 1'b0;
    wait_clk(2);
    reset = 1'b0;
    #2;
    tests++;
    if (dataout !== 32'h0 || kbd_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_outputs: dataout=%h ready=%b want 0/0", dataout, kbd_ready);
    end
    ps2_clk = 1'b1;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(3);
    rd(A_STAT, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL rst_mid_status: got %h want 0", d); end
    send(8'h29);
    rd(A_DATA, d);
    tests++;
    if (d !== 32'h29) begin fails++; $display("FAIL rst_next_frame: got %h want 29", d); end
  endtask

  initial begin
    reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rdaddr   = '0;
    rdclk    = 1'b0;
    wait_clk(4);
    test_reset;
    reset = 1'b1;
    wait_clk(2);
    test_reset;
    test_single;
    test_overflow;
    test_frame_errors;
    test_full_push_pop;
    test_decode;
    test_timeout;
    test_reset_mid_frame;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kbd_ctrl.md
KBD_CTRL -- requirements
Module: kbd_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, is the scancode FIFO entry count and SHALL be a power of two in the range 2..64.
REQ-002 Parameter TIMEOUT_CYC, default 50000, is the number of clock cycles without a PS/2 falling edge before a partial frame is abandoned.
REQ-003 Port `clock`, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 Port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port `ps2_clk`, input, 1 bit: raw PS/2 clock from the keyboard, asynchronous to `clock`.
REQ-006 Port `ps2_data`, input, 1 bit: raw PS/2 data, asynchronous to `clock`.
REQ-007 Port `rdaddr`, input, 32 bits: CPU data-read address; the block decodes `rdaddr[31:20]==12'h003`.
REQ-008 Port `rdclk`, input, 1 bit: one-cycle CPU read strobe, synchronous to `clock`.
REQ-009 Port `dataout`, output, 32 bits: read data, registered.
REQ-010 Port `kbd_ready`, output, 1 bit: FIFO non-empty.

Function
REQ-011 `ps2_clk` and `ps2_data` SHALL each pass through a 2-flop synchronizer; a falling edge is a synchronized 1->0 transition, sampled once.
REQ-012 Receiver FSM states are IDLE, DATA, PARITY, STOP; on each falling edge: IDLE->DATA only if data=0 (start bit), otherwise stay in IDLE.
REQ-013 DATA SHALL shift 8 bits LSB-first and move to PARITY after the 8th bit; PARITY->STOP on the next edge; STOP->IDLE on the next edge.
REQ-014 A frame SHALL be pushed only if the data bits plus the parity bit have odd parity and the stop bit is 1; otherwise it is discarded and sticky `frame_err` is set.
REQ-015 Push SHALL occur on the cycle after the STOP edge; if the FIFO is full, the byte is dropped and sticky `overflow` is set.
REQ-016 Offset `rdaddr[3:0]`=0x0 (DATA): read returns {24'b0, head byte}; a read while non-empty pops; a read while empty returns 0 and causes no state change.
REQ-017 Offset 0x4 (STATUS): read returns {29'b0, overflow, frame_err, kbd_ready}; the same read clears `overflow` and `frame_err`.
REQ-018 Other offsets, or a `rdaddr[31:20]` miss, SHALL return 0 with no side effects.
REQ-019 `dataout` SHALL be valid one clock after `rdclk`, and SHALL hold that value until the next decoded read.
REQ-020 Simultaneous push and pop SHALL both take effect; the count is unchanged, including when full (the pop frees space, so the push is accepted with no overflow).
REQ-021 A sticky set and a STATUS clear in the same cycle: set wins.
REQ-022 Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; the count is log2(FIFO_DEPTH)+1 bits.

Reset
REQ-023 While `reset`=0: FSM=IDLE, pointers=0, count=0, shift register=0, sticky bits=0, synchronizer flops=1, `dataout`=0, `kbd_ready`=0.
REQ-024 A reset asserted mid-frame SHALL abandon the frame with no push and no error flag.

Configuration
REQ-025 With macro KBD_TIMEOUT_EN defined: a counter resets on every falling edge; in any non-IDLE state, reaching TIMEOUT_CYC forces IDLE, discards the partial byte and sets `frame_err`.
REQ-026 Without KBD_TIMEOUT_EN: no counter exists, and the FSM leaves non-IDLE states only on PS/2 edges.

Structure
REQ-027 Package kbd_pkg SHALL hold the FSM state enum, the DATA/STATUS offset constants, the STATUS bit indices and the 12'h003 region constant.
REQ-028 Sub-module ps2_rx SHALL contain the synchronizer, FSM, parity/stop check and timeout; it outputs a byte plus a one-cycle valid and error pulse.
REQ-029 The FIFO and register decode SHALL reside in kbd_ctrl.

Verification
REQ-030 Scenario: frame 0x1C with correct odd parity, then read 0x00300000 -> `dataout`=0x0000001C one cycle after `rdclk`; `kbd_ready` 1->0.
REQ-031 Scenario: 9 valid frames 0x01..0x09 with FIFO_DEPTH=8, no reads -> STATUS=0x5 (overflow=1, ready=1); 8 DATA reads return 0x01..0x08; the next STATUS read returns 0x0.
REQ-032 Scenario: frame 0x5A with a wrong parity bit -> no push; STATUS=0x2; a second STATUS read returns 0x0.
REQ-033 Scenario: FIFO full and a DATA read in the same cycle as a push -> the head is returned; count stays 8; overflow stays 0.
REQ-034 Scenario: with KBD_TIMEOUT_EN, stop after 4 data bits and wait TIMEOUT_CYC+2 cycles -> FSM=IDLE, frame_err=1; a following valid frame 0x29 is received correctly.
REQ-035 Scenario: `reset` pulsed low mid-frame -> all outputs 0; STATUS=0x0 after release.
